// File: rtl/test_usart.sv
`timescale 1ns / 1ps
// test_usart: continuous USART transmitter plus receiver, bit rate from sampled CLK_B strobe.
// Ports: CLK system clock; CLR async active-low reset; CLK_B bit-rate strobe (rise = tx tick,
// fall = rx tick); CLR_Rec sync active-low receiver clear; Data_Tx word to send; Rx serial in;
// Tx serial out; Data_Rx last good word; parity_err parity mismatch of last good frame.
// Build option: define TEST_USART_PARITY_EN for an 11-bit frame with even parity,
// otherwise a 10-bit frame is used and parity_err is constant 0.
module test_usart #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       CLK,
  input  logic       CLR,
  input  logic       CLK_B,
  input  logic       CLR_Rec,
  input  logic [7:0] Data_Tx,
  input  logic       Rx,
  output logic       Tx,
  output logic [7:0] Data_Rx,
  output logic       parity_err
);
`ifdef TEST_USART_PARITY_EN
  localparam int FW = 11;
`else
  localparam int FW = 10;
`endif
  logic [SYNC_STAGES-1:0] b_sync, r_sync;
  logic b_q;
  logic b_s, rx_s, tx_tick, rx_tick;
  assign b_s = b_sync[SYNC_STAGES-1];
  assign rx_s = r_sync[SYNC_STAGES-1];
  assign tx_tick = b_s & ~b_q;
  assign rx_tick = ~b_s & b_q;
  always_ff @(posedge CLK or negedge CLR)
    if (!CLR) begin
      b_sync <= '0;
      r_sync <= '0;
      b_q <= 1'b0;
    end else begin
      b_sync <= {b_sync[SYNC_STAGES-2:0], CLK_B};
      r_sync <= {r_sync[SYNC_STAGES-2:0], Rx};
      b_q <= b_s;
    end
  typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;
  tx_state_t tx_state;
  logic [FW-1:0] tx_sh;
  logic [FW-1:0] tx_load;
  logic [3:0] tx_cnt;
`ifdef TEST_USART_PARITY_EN
  assign tx_load = {1'b1, ^Data_Tx, Data_Tx, 1'b0};
`else
  assign tx_load = {1'b1, Data_Tx, 1'b0};
`endif
  // Tx is the low bit of the shift register, so it is registered and idles high
  // via the all-ones reset/fill value; the stop bit's tick reloads without a gap.
  always_ff @(posedge CLK or negedge CLR)
    if (!CLR) begin
      tx_state <= TX_IDLE;
      tx_sh <= '1;
      tx_cnt <= '0;
    end else if (tx_tick) begin
      if (tx_state == TX_IDLE || tx_cnt == 4'(FW - 1)) begin
        tx_state <= TX_SEND;
        tx_sh <= tx_load;
        tx_cnt <= '0;
      end else begin
        tx_sh <= {1'b1, tx_sh[FW-1:1]};
        tx_cnt <= tx_cnt + 4'd1;
      end
    end
  assign Tx = tx_sh[0];
  typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
  rx_state_t rx_state;
  logic [7:0] rx_sh;
  logic [2:0] rx_cnt;
`ifdef TEST_USART_PARITY_EN
  logic rx_par;
  always_ff @(posedge CLK or negedge CLR)
    if (!CLR) begin
      rx_state <= RX_IDLE;
      rx_sh <= '0;
      rx_cnt <= '0;
      rx_par <= 1'b0;
      Data_Rx <= '0;
      parity_err <= 1'b0;
    end else if (!CLR_Rec) begin
      rx_state <= RX_IDLE;
      rx_sh <= '0;
      rx_cnt <= '0;
      rx_par <= 1'b0;
      Data_Rx <= '0;
      parity_err <= 1'b0;
    end else if (rx_tick) begin
      case (rx_state)
        RX_IDLE: if (!rx_s) begin
          rx_state <= RX_DATA;
          rx_cnt <= '0;
        end
        RX_DATA: begin
          rx_sh <= {rx_s, rx_sh[7:1]};
          rx_cnt <= rx_cnt + 3'd1;
          rx_state <= rx_cnt == 3'd7 ? RX_PARITY : RX_DATA;
        end
        RX_PARITY: begin
          rx_par <= rx_s;
          rx_state <= RX_STOP;
        end
        default: begin
          // A low stop bit is a framing error: the frame is dropped silently.
          if (rx_s) begin
            Data_Rx <= rx_sh;
            parity_err <= rx_par ^ (^rx_sh);
          end
          rx_state <= RX_IDLE;
        end
      endcase
    end
`else
  always_ff @(posedge CLK or negedge CLR)
    if (!CLR) begin
      rx_state <= RX_IDLE;
      rx_sh <= '0;
      rx_cnt <= '0;
      Data_Rx <= '0;
    end else if (!CLR_Rec) begin
      rx_state <= RX_IDLE;
      rx_sh <= '0;
      rx_cnt <= '0;
      Data_Rx <= '0;
    end else if (rx_tick) begin
      case (rx_state)
        RX_IDLE: if (!rx_s) begin
          rx_state <= RX_DATA;
          rx_cnt <= '0;
        end
        RX_DATA: begin
          rx_sh <= {rx_s, rx_sh[7:1]};
          rx_cnt <= rx_cnt + 3'd1;
          rx_state <= rx_cnt == 3'd7 ? RX_STOP : RX_DATA;
        end
        default: begin
          if (rx_s) Data_Rx <= rx_sh;
          rx_state <= RX_IDLE;
        end
      endcase
    end
  assign parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_test_usart.sv
`timescale 1ns / 1ps
// tb_test_usart: loopback and injected-frame checks for test_usart with a result scoreboard.
module tb_test_usart;
`ifdef TEST_USART_PARITY_EN
  localparam bit PAR = 1'b1;
  localparam int FW = 11;
`else
  localparam bit PAR = 1'b0;
  localparam int FW = 10;
`endif
  logic clk = 1'b0, clr = 1'b1, clk_b = 1'b0, clr_rec = 1'b1, loop = 1'b1, rx_inj = 1'b1;
  logic [7:0] data_tx = 8'h09;
  logic tx, perr, rx;
  logic [7:0] data_rx;
  typedef struct {logic [7:0] d; logic p;} exp_t;
  typedef struct {logic [7:0] d; logic flip; logic stop; logic [7:0] ed; logic ep;} vec_t;
  exp_t sb[$];
  vec_t vecs[8];
  int n_vec = 0, n_err = 0;

  assign rx = loop ? tx : rx_inj;

  test_usart dut (
    .CLK(clk), .CLR(clr), .CLK_B(clk_b), .CLR_Rec(clr_rec), .Data_Tx(data_tx),
    .Rx(rx), .Tx(tx), .Data_Rx(data_rx), .parity_err(perr)
  );

  always #100 clk = ~clk;
  initial begin
    #50;
    forever #1000 clk_b = ~clk_b;
  end

  function automatic logic [10:0] frame(input logic [7:0] d, input logic flip, input logic stop);
    return PAR ? {stop, (^d) ^ flip, d, 1'b0} : {1'b1, stop, d, 1'b0};
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic rx_check(input string name);
    exp_t e;
    if (sb.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: scoreboard empty", name);
      return;
    end
    e = sb.pop_front();
    check({name, " data"}, data_rx, e.d);
    check({name, " perr"}, {7'd0, perr}, {7'd0, e.p});
  endtask

  task automatic wait_start();
    for (int i = 0; i < 60 && tx !== 1'b0; i++) @(posedge clk) #1;
    check("tx frame start", {7'd0, tx}, 8'd0);
  endtask

  // mode: 0 check receiver afterwards, 1 CLR_Rec pulse mid-frame,
  // 2 CLR pulse mid-frame (frame aborted), 3 change Data_Tx mid-frame
  task automatic capture(input logic [7:0] d, input int mode);
    logic [10:0] f;
    f = frame(d, 1'b0, 1'b1);
    for (int b = 0; b < FW; b++) begin
      @(negedge clk_b) #1;
      check($sformatf("tx bit %0d of %h", b, d), {7'd0, tx}, {7'd0, f[b]});
      if (b == 4 && mode == 1) begin
        clr_rec = 1'b0;
        @(posedge clk) #1;
        clr_rec = 1'b1;
        check("clr_rec data", data_rx, 8'h00);
        check("clr_rec perr", {7'd0, perr}, 8'd0);
      end
      if (b == 4 && mode == 2) begin
        clr = 1'b0;
        #1;
        check("clr tx", {7'd0, tx}, 8'd1);
        check("clr data", data_rx, 8'h00);
        check("clr perr", {7'd0, perr}, 8'd0);
        #300 clr = 1'b1;
        return;
      end
      if (b == 4 && mode == 3) data_tx = 8'h07;
    end
    if (mode == 0 || mode == 3) begin
      #700;
      rx_check($sformatf("loop rx %h", d));
    end
  endtask

  task automatic inject(input logic [7:0] d, input logic flip, input logic stop);
    logic [10:0] f;
    f = frame(d, flip, stop);
    for (int b = 0; b < FW; b++) begin
      @(posedge clk_b) #1;
      rx_inj = f[b];
    end
    @(posedge clk_b) #1;
    rx_inj = 1'b1;
  endtask

  initial begin
    vecs[0] = '{8'h09, 1'b0, 1'b1, 8'h09, 1'b0};
    vecs[1] = '{8'h09, 1'b1, 1'b1, 8'h09, PAR};
    vecs[2] = '{8'h09, 1'b0, 1'b1, 8'h09, 1'b0};
    vecs[3] = '{8'h3C, 1'b0, 1'b0, 8'h09, 1'b0};
    vecs[4] = '{8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0};
    vecs[5] = '{8'h81, 1'b1, 1'b1, 8'h81, PAR};
    vecs[6] = '{8'h5A, 1'b0, 1'b0, 8'h81, PAR};
    vecs[7] = '{8'hFF, 1'b0, 1'b1, 8'hFF, 1'b0};
    #1 clr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #40;
      check("reset tx", {7'd0, tx}, 8'd1);
      check("reset data", data_rx, 8'h00);
      check("reset perr", {7'd0, perr}, 8'd0);
    end
    #30 clr = 1'b1;
    sb.push_back('{d: 8'h09, p: 1'b0});
    wait_start();
    capture(8'h09, 0);
    sb.push_back('{d: 8'h09, p: 1'b0});
    capture(8'h09, 3);
    sb.push_back('{d: 8'h07, p: 1'b0});
    capture(8'h07, 0);
    capture(8'h07, 1);
    capture(8'h07, 2);
    sb.push_back('{d: 8'h07, p: 1'b0});
    wait_start();
    capture(8'h07, 0);
    loop = 1'b0;
    for (int i = 0; i < 8; i++) begin
      sb.push_back('{d: vecs[i].ed, p: vecs[i].ep});
      inject(vecs[i].d, vecs[i].flip, vecs[i].stop);
      rx_check($sformatf("inject %0d", i));
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
